// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: default depth and the entry layout.
package store_buffer_pkg;

  localparam int DEPTH_DEFAULT = 4;

  // One buffered store: word address (byte offset dropped) and full data word.
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match store-to-load forwarding lookup for the store buffer.
// Scans from the head (oldest) toward the tail so the last hit is the youngest.
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int PW   = $clog2(DEPTH)
) (
  input  sb_entry_t         i_entries [DEPTH],
  input  logic [DEPTH-1:0]  i_valid,
  input  logic [PW-1:0]     i_head,
  input  logic [29:0]       i_addr,
  output logic              o_hit,
  output logic [31:0]       o_data
);

  // Walk entries oldest to youngest; a later match overrides an earlier one.
  always_comb begin
    logic [PW-1:0] w_idx;
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = i_head + PW'(k);
      if (i_valid[w_idx] && (i_entries[w_idx].addr == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the memory stage and a write-acknowledged
// backing memory. Stores are queued and drained one at a time at the head;
// loads are forwarded from the youngest matching buffered store, otherwise
// they read the backing memory combinationally.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        sb_empty
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  sb_entry_t        r_entries [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic             w_full;
  logic             w_nonempty;
  logic             w_enq;
  logic             w_pop;
  logic [DEPTH-1:0] w_valid_nxt;
  logic             w_hit;
  logic [31:0]      w_fwd_data;

  // An ack arriving while full does not free a slot until the next cycle,
  // so the stall depends only on the registered count.
  assign w_full     = (r_count == FULL_CNT);
  assign w_nonempty = (r_count != '0);
  assign w_enq      = MemWriteM & ~w_full;
  assign w_pop      = w_nonempty & mem_ack;

  assign StallM     = MemWriteM & w_full;
  assign sb_empty   = ~w_nonempty;

  // Head entry is presented to memory until acked; pointer only moves on pop.
  assign mem_req    = w_nonempty;
  assign mem_addr   = {r_entries[r_head].addr, 2'b00};
  assign mem_wdata  = r_entries[r_head].data;

  assign mem_raddr  = ALUResultM;

  // Next valid mask: the popped head and the enqueued tail can only coincide
  // when empty (no pop) or full (no enqueue), so the order is immaterial.
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_pop) w_valid_nxt[r_head] = 1'b0;
    if (w_enq) w_valid_nxt[r_tail] = 1'b1;
  end

  // FIFO control: pointers, occupancy and valid mask; reset drops all stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_pop) r_head <= r_head + PTR_ONE;
      if (w_enq) r_tail <= r_tail + PTR_ONE;
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      r_valid <= w_valid_nxt;
    end
  end

  // Entry storage: written at the tail on enqueue, never reset (valid gates use).
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_entries[r_tail] <= '{addr: ALUResultM[31:2], data: WriteDataM};
    end
  end

  // The head being acked this cycle is still valid here, so it still forwards.
  sb_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd (
    .i_entries (r_entries),
    .i_valid   (r_valid),
    .i_head    (r_head),
    .i_addr    (ALUResultM[31:2]),
    .o_hit     (w_hit),
    .o_data    (w_fwd_data)
  );

  assign ReadDataM = w_hit ? w_fwd_data : mem_rdata;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed table vectors, hand sequences for the
// wrap and reset corners, and randomized traffic against a queue model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        sb_empty;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .sb_empty   (sb_empty)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain queue of pending stores, oldest at index 0.
  typedef struct { logic [29:0] a; logic [31:0] d; } mst_t;
  mst_t mq[$];

  typedef struct {
    bit          chk;
    logic        rst, we;
    logic [31:0] a, wd;
    logic        ack;
    logic [31:0] rd;
    logic        st, rq;
    logic [31:0] ma, mw;
    logic        em;
    logic [31:0] er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit c, logic r, logic we, logic [31:0] a, logic [31:0] wd,
                              logic ack, logic [31:0] rd, logic st, logic rq,
                              logic [31:0] ma, logic [31:0] mw, logic em, logic [31:0] er);
    vec_t v;
    v.chk = c; v.rst = r; v.we = we; v.a = a; v.wd = wd; v.ack = ack; v.rd = rd;
    v.st = st; v.rq = rq; v.ma = ma; v.mw = mw; v.em = em; v.er = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Drive one cycle's inputs and move to the sampling point (falling edge).
  task automatic apply(input logic r, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic ack, input logic [31:0] rd);
    reset = r; MemWriteM = we; ALUResultM = a; WriteDataM = wd;
    mem_ack = ack; mem_rdata = rd;
    @(negedge clk);
  endtask

  // Advance through the rising edge, updating the model from the held inputs.
  task automatic commit();
    bit pop, enq;
    mst_t e;
    pop = (mq.size() != 0) && mem_ack;
    enq = MemWriteM && (mq.size() < DEPTH);
    @(posedge clk);
    if (reset) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (enq) begin
        e.a = ALUResultM[31:2]; e.d = WriteDataM;
        mq.push_back(e);
      end
    end
    #1;
  endtask

  // Compare all outputs against the model's view of the current cycle.
  task automatic check_model(input string tag);
    logic [31:0] erd;
    erd = mem_rdata;
    foreach (mq[i]) if (mq[i].a == ALUResultM[31:2]) erd = mq[i].d;
    chk({tag, ".stall"}, {31'd0, StallM}, {31'd0, MemWriteM && (mq.size() == DEPTH)});
    chk({tag, ".req"},   {31'd0, mem_req}, {31'd0, mq.size() != 0});
    chk({tag, ".empty"}, {31'd0, sb_empty}, {31'd0, mq.size() == 0});
    chk({tag, ".rdata"}, ReadDataM, erd);
    chk({tag, ".raddr"}, mem_raddr, ALUResultM);
    if (mq.size() != 0) begin
      chk({tag, ".maddr"}, mem_addr, {mq[0].a, 2'b00});
      chk({tag, ".mwdata"}, mem_wdata, mq[0].d);
    end
  endtask

  task automatic mcyc(input string tag, input logic r, input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic ack, input logic [31:0] rd);
    apply(r, we, a, wd, ack, rd);
    check_model(tag);
    commit();
  endtask

  initial begin
    // Scenario 1: single store, ack tied high.
    tbl.push_back(mk(0, 1, 0, 32'h0,   32'h0,        1, 32'h1111, 0, 0, 0, 0, 1, 32'h1111));
    tbl.push_back(mk(1, 0, 1, 32'h100, 32'hAAAA5555, 1, 32'h1111, 0, 0, 0, 0, 1, 32'h1111));
    tbl.push_back(mk(1, 0, 0, 32'h100, 32'h0,        1, 32'h2222, 0, 1, 32'h100, 32'hAAAA5555, 0, 32'hAAAA5555));
    tbl.push_back(mk(1, 0, 0, 32'h100, 32'h0,        1, 32'h2222, 0, 0, 0, 0, 1, 32'h2222));
    // Scenario 2: fill, stall on fifth, stall holds through ack, clears next cycle.
    tbl.push_back(mk(0, 1, 0, 32'h0,  32'h0,  0, 32'hDEAD0000, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 32'h0,  32'h10, 0, 32'hDEAD0000, 0, 0, 0, 0, 1, 32'hDEAD0000));
    tbl.push_back(mk(1, 0, 1, 32'h4,  32'h11, 0, 32'hDEAD0000, 0, 1, 32'h0, 32'h10, 0, 32'hDEAD0000));
    tbl.push_back(mk(1, 0, 1, 32'h8,  32'h12, 0, 32'hDEAD0000, 0, 1, 32'h0, 32'h10, 0, 32'hDEAD0000));
    tbl.push_back(mk(1, 0, 1, 32'hC,  32'h13, 0, 32'hDEAD0000, 0, 1, 32'h0, 32'h10, 0, 32'hDEAD0000));
    tbl.push_back(mk(1, 0, 1, 32'h10, 32'h14, 0, 32'hDEAD0000, 1, 1, 32'h0, 32'h10, 0, 32'hDEAD0000));
    tbl.push_back(mk(1, 0, 1, 32'h10, 32'h14, 1, 32'hDEAD0000, 1, 1, 32'h0, 32'h10, 0, 32'hDEAD0000));
    tbl.push_back(mk(1, 0, 1, 32'h10, 32'h14, 0, 32'hDEAD0000, 0, 1, 32'h4, 32'h11, 0, 32'hDEAD0000));
    tbl.push_back(mk(1, 0, 0, 32'h10, 32'h0,  0, 32'hDEAD0000, 0, 1, 32'h4, 32'h11, 0, 32'h14));
    tbl.push_back(mk(1, 0, 1, 32'h10, 32'h99, 0, 32'hDEAD0000, 1, 1, 32'h4, 32'h11, 0, 32'h14));
    // Scenario 3: youngest match wins, byte offset ignored, miss reads memory.
    tbl.push_back(mk(0, 1, 0, 32'h0,  32'h0, 0, 32'h5A5A5A5A, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 32'h20, 32'h1, 0, 32'h5A5A5A5A, 0, 0, 0, 0, 1, 32'h5A5A5A5A));
    tbl.push_back(mk(1, 0, 1, 32'h20, 32'h2, 0, 32'h5A5A5A5A, 0, 1, 32'h20, 32'h1, 0, 32'h1));
    tbl.push_back(mk(1, 0, 0, 32'h22, 32'h0, 0, 32'h5A5A5A5A, 0, 1, 32'h20, 32'h1, 0, 32'h2));
    tbl.push_back(mk(1, 0, 0, 32'h24, 32'h0, 0, 32'h5A5A5A5A, 0, 1, 32'h20, 32'h1, 0, 32'h5A5A5A5A));

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].ack, tbl[i].rd);
      if (tbl[i].chk) begin
        chk($sformatf("v%0d.stall", i), {31'd0, StallM},   {31'd0, tbl[i].st});
        chk($sformatf("v%0d.req", i),   {31'd0, mem_req},  {31'd0, tbl[i].rq});
        chk($sformatf("v%0d.empty", i), {31'd0, sb_empty}, {31'd0, tbl[i].em});
        chk($sformatf("v%0d.rdata", i), ReadDataM, tbl[i].er);
        chk($sformatf("v%0d.raddr", i), mem_raddr, tbl[i].a);
        if (tbl[i].rq) begin
          chk($sformatf("v%0d.maddr", i),  mem_addr,  tbl[i].ma);
          chk($sformatf("v%0d.mwdata", i), mem_wdata, tbl[i].mw);
        end
      end
      commit();
    end

    // Scenario 4: steer head to index 3 with count 2, then enqueue+ack together.
    mcyc("s4", 1, 0, 32'h0, 32'h0, 0, 32'h0);
    mcyc("s4", 0, 1, 32'h300, 32'hA0, 0, 32'h0);
    mcyc("s4", 0, 1, 32'h304, 32'hA1, 0, 32'h0);
    mcyc("s4", 0, 1, 32'h308, 32'hA2, 0, 32'h0);
    mcyc("s4", 0, 1, 32'h30C, 32'hA3, 1, 32'h0);
    mcyc("s4", 0, 0, 32'h0,   32'h0,  1, 32'h0);
    mcyc("s4", 0, 0, 32'h0,   32'h0,  1, 32'h0);
    mcyc("s4", 0, 1, 32'h310, 32'hA4, 0, 32'h0);
    mcyc("s4", 0, 1, 32'h314, 32'hA5, 1, 32'h0);
    chk("s4.count2", {31'd0, mem_req}, 32'd1);
    mcyc("s4", 0, 0, 32'h30C, 32'h0, 1, 32'h0);
    mcyc("s4", 0, 0, 32'h310, 32'h0, 1, 32'h0);
    mcyc("s4", 0, 0, 32'h314, 32'h0, 0, 32'hBEEF);
    chk("s4.drained", {31'd0, sb_empty}, 32'd1);

    // Scenario 5: reset mid-handshake discards everything pending.
    mcyc("s5", 0, 1, 32'h40, 32'hC0, 0, 32'h0);
    mcyc("s5", 0, 1, 32'h44, 32'hC1, 0, 32'h0);
    mcyc("s5", 0, 1, 32'h48, 32'hC2, 0, 32'h0);
    mcyc("s5", 1, 0, 32'h44, 32'h0,  0, 32'h0);
    apply(0, 0, 32'h44, 32'h0, 0, 32'h77);
    chk("s5.req",   {31'd0, mem_req},  32'd0);
    chk("s5.empty", {31'd0, sb_empty}, 32'd1);
    chk("s5.rdata", ReadDataM, 32'h77);
    check_model("s5");
    commit();

    // Randomized traffic over a small address window to exercise forwarding.
    for (int n = 0; n < 400; n++) begin
      logic r, we, ack;
      logic [31:0] a;
      r   = ($urandom_range(0, 39) == 0);
      we  = $urandom_range(0, 1);
      ack = $urandom_range(0, 2) != 0;
      a   = 32'h1000 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      mcyc("rnd", r, we, a, $urandom, ack, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of buffered stores; SHALL be a power of two, 2 to 16.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: MemWriteM  input  1  memory-stage store request.
REQ-005 Port: ALUResultM  input  32  memory-stage byte address for both loads and stores.
REQ-006 Port: WriteDataM  input  32  memory-stage store data, full word.
REQ-007 Port: ReadDataM  output  32  load data returned to the memory stage.
REQ-008 Port: StallM  output  1  store refused, pipeline SHALL hold the memory stage.
REQ-009 Port: mem_req  output  1  write request to the backing memory.
REQ-010 Port: mem_addr  output  32  write address, head entry.
REQ-011 Port: mem_wdata  output  32  write data, head entry.
REQ-012 Port: mem_ack  input  1  backing memory accepted the write this cycle.
REQ-013 Port: mem_raddr  output  32  read address to the backing memory, combinational read.
REQ-014 Port: mem_rdata  input  32  read data from the backing memory.
REQ-015 Port: sb_empty  output  1  no buffered stores, used for fence and drain.

Function
REQ-016 The buffer SHALL be an in-order FIFO of DEPTH entries of {addr[31:2], data[31:0]}, with head pointer, tail pointer and a count of 0 to DEPTH.
REQ-017 Enqueue: when MemWriteM=1 and count<DEPTH, the tail SHALL take {ALUResultM[31:2], WriteDataM} at the edge; ALUResultM[1:0] SHALL be ignored.
REQ-018 StallM SHALL equal MemWriteM & (count==DEPTH), combinationally; an ack in the same cycle SHALL NOT lift the stall, and no enqueue SHALL occur while stalled.
REQ-019 Drain: mem_req SHALL equal (count!=0); mem_addr={head.addr,2'b00} and mem_wdata=head.data SHALL be held stable until mem_ack.
REQ-020 When mem_req & mem_ack, the head SHALL pop at the edge; mem_ack while mem_req=0 SHALL be ignored.
REQ-021 Simultaneous enqueue and pop SHALL leave count unchanged and advance both pointers.
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-023 Pop and enqueue latency SHALL each be one edge; a store enqueued at edge N SHALL drive mem_req from cycle N+1 if it is at the head.
REQ-024 mem_raddr SHALL equal ALUResultM.
REQ-025 ReadDataM SHALL be the data of the youngest valid entry whose addr equals ALUResultM[31:2]; if none matches, it SHALL be mem_rdata. The path SHALL be combinational.
REQ-026 The head entry being acked in the current cycle SHALL still participate in forwarding that cycle.
REQ-027 A store and a load never share a cycle; forwarding SHALL be evaluated regardless of MemWriteM.
REQ-028 sb_empty SHALL equal (count==0).

Reset
REQ-029 When reset=1 at an edge, count, head and tail SHALL become 0 and all entries SHALL be invalid; any pending stores SHALL be discarded, including one mid-handshake.
REQ-030 After reset: mem_req=0, StallM=MemWriteM & 0 = 0, sb_empty=1, and ReadDataM=mem_rdata.
REQ-031 Entry data storage SHALL NOT require reset.

Structure
REQ-032 A shared package SHALL hold DEPTH_DEFAULT=4 and the entry typedef {logic [29:0] addr; logic [31:0] data}.
REQ-033 Youngest-match forwarding SHALL be a sub-module, sb_fwd_match, which is combinational and takes the entries, valid mask, head and lookup address, and returns hit and data.
REQ-034 FIFO control and storage SHALL remain in store_buffer.

Verification
REQ-035 Scenario 1: after reset, store 0x100/0xAAAA5555 with mem_ack tied 1 -> mem_req=1 for one cycle at addr 0x100, then sb_empty=1.
REQ-036 Scenario 2: mem_ack=0, four stores to 0x0,0x4,0x8,0xC, then a fifth -> StallM=1 on the fifth with count held at 4; with ack pulsed once -> the stall clears the next cycle and the fifth enqueues.
REQ-037 Scenario 3: mem_ack=0, stores 0x20=1 then 0x20=2, then a load 0x22 -> ReadDataM=2 (youngest wins, low bits ignored); a load 0x24 -> ReadDataM=mem_rdata.
REQ-038 Scenario 4: count=2 with head at index 3 (DEPTH=4), with enqueue and ack in the same cycle -> count stays 2, the tail wraps to 1, and the drain order is preserved.
REQ-039 Scenario 5: three pending stores, with reset asserted while mem_req=1 and mem_ack=0 -> next cycle mem_req=0, sb_empty=1, and a load of a previously stored address returns mem_rdata.
